// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out `amount` one coin at a time over a
// valid/ack hopper handshake, largest available coin first.
module change_dispenser #(
    parameter logic [3:0] COIN_A = 4'd5,
    parameter logic [3:0] COIN_B = 4'd2,
    parameter logic [3:0] COIN_C = 4'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] amount,
    input  logic       empty_a,
    input  logic       empty_b,
    input  logic       empty_c,
    input  logic       coin_ack,
    output logic       coin_valid,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] remaining,
    output logic [3:0] coin_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic       busy_n, done_n, error_n, valid_n;
    logic [1:0] sel_n, pick;
    logic [3:0] rem_n, cnt_n, coin_value;

    assign state_dbg = state;

    // Handshake: coin_valid/coin_sel are held constant from the SELECT edge
    // until an edge that samples coin_ack=1; that edge retires the coin and
    // drops coin_valid. coin_ack is only acted on while coin_valid is high.
    always_comb begin
        case (coin_sel)
            2'b01:   coin_value = COIN_A;
            2'b10:   coin_value = COIN_B;
            2'b11:   coin_value = COIN_C;
            default: coin_value = 4'd0;
        endcase
    end

    // Empty flags only matter here, so a flag changing mid-ISSUE is harmless.
    always_comb begin
        if (!empty_a && COIN_A <= remaining)      pick = 2'b01;
        else if (!empty_b && COIN_B <= remaining) pick = 2'b10;
        else if (!empty_c && COIN_C <= remaining) pick = 2'b11;
        else                                      pick = 2'b00;
    end

    always_comb begin
        state_n = state;
        busy_n  = busy;
        done_n  = 1'b0;
        error_n = 1'b0;
        valid_n = coin_valid;
        sel_n   = coin_sel;
        rem_n   = remaining;
        cnt_n   = coin_count;
        case (state)
            IDLE: begin
                if (start) begin
                    rem_n = amount;
                    cnt_n = 4'd0;
                    if (amount != 4'd0) begin
                        busy_n  = 1'b1;
                        state_n = SELECT;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SELECT: begin
                if (pick != 2'b00) begin
                    sel_n   = pick;
                    valid_n = 1'b1;
                    state_n = ISSUE;
                end else begin
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (coin_ack) begin
                    rem_n   = remaining - coin_value;
                    cnt_n   = coin_count + 4'd1;
                    valid_n = 1'b0;
                    sel_n   = 2'b00;
                    if (rem_n == 4'd0) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = SELECT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            coin_valid <= 1'b0;
            coin_sel   <= 2'b00;
            remaining  <= 4'd0;
            coin_count <= 4'd0;
        end else begin
            state      <= state_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            coin_valid <= valid_n;
            coin_sel   <= sel_n;
            remaining  <= rem_n;
            coin_count <= cnt_n;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, reset-in-ISSUE sequence,
// and random transactions scored against a greedy payout model.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset, start, empty_a, empty_b, empty_c, coin_ack;
    logic [3:0] amount;
    logic       coin_valid, busy, done, error;
    logic [1:0] coin_sel, state_dbg;
    logic [3:0] remaining, coin_count;

    change_dispenser dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .empty_a(empty_a), .empty_b(empty_b), .empty_c(empty_c),
        .coin_ack(coin_ack), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .busy(busy), .done(done), .error(error), .remaining(remaining),
        .coin_count(coin_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    logic [3:0] exp_rem;
    logic       exp_err;

    typedef struct {
        logic [3:0]  amt;
        logic        ea, eb, ec;
        int          dly;
        bit          poke;
        int          n;
        logic [15:0] seq;
        logic [3:0]  rem;
        logic        err;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Greedy payout with coin values 5/2/1 and hopper availability.
    task automatic model(input int amt, input logic ea, input logic eb, input logic ec);
        int rem;
        rem = amt;
        exp_q.delete();
        while (rem > 0) begin
            if (!ea && rem >= 5)      begin exp_q.push_back(2'b01); rem -= 5; end
            else if (!eb && rem >= 2) begin exp_q.push_back(2'b10); rem -= 2; end
            else if (!ec && rem >= 1) begin exp_q.push_back(2'b11); rem -= 1; end
            else break;
        end
        exp_rem = rem[3:0];
        exp_err = (rem != 0);
    endtask

    // Entered at the negedge right after the accepting edge.
    task automatic monitor_txn(input int amt, input int ack_dly, input bit poke, input logic ea);
        int         gap, waited;
        bit         in_coin, fin, done_seen, err_seen;
        logic [1:0] cur_sel;
        got_q.delete();
        gap = 0; waited = 0; in_coin = 0; fin = 0; done_seen = 0; err_seen = 0; cur_sel = 2'b00;
        check("busy_after_accept", busy, amt != 0);
        for (int i = 0; i < 200 && !fin; i++) begin
            if (poke && i == 2) begin start = 1'b1; amount = 4'd15; end
            if (poke && i == 3) start = 1'b0;
            if (done || error) begin
                check("done_error_exclusive", done & error, 0);
                done_seen = done;
                err_seen  = error;
                fin = 1;
            end else if (coin_valid) begin
                if (!in_coin) begin
                    in_coin = 1; waited = 0; cur_sel = coin_sel;
                    if (got_q.size() == 0) check("first_coin_latency", i, 1);
                    else                   check("coin_gap", gap, 1);
                end else begin
                    check("sel_stable", coin_sel, cur_sel);
                end
                if (ack_dly == 0 || waited == ack_dly) begin
                    coin_ack = 1'b1;
                    empty_a  = ea;
                    got_q.push_back(cur_sel);
                    in_coin = 0;
                    gap = 0;
                end else begin
                    coin_ack = 1'b0;
                    empty_a  = 1'($urandom_range(0, 1));
                    waited++;
                end
            end else begin
                if (in_coin) begin check("valid_held", 0, 1); in_coin = 0; end
                gap++;
                if (ack_dly != 0) coin_ack = 1'b0;
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) check("txn_timeout", 0, 1);
        coin_ack = 1'b0;
        empty_a  = ea;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("error_one_cycle", error, 0);
        check("busy_end", busy, 0);
        check("valid_end", coin_valid, 0);
        check("n_coins", got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            check("coin_sel_seq", got_q[k], exp_q[k]);
        check("remaining", remaining, exp_rem);
        check("coin_count", coin_count, exp_q.size());
        check("done_seen", done_seen, !exp_err);
        check("error_seen", err_seen, exp_err);
    endtask

    task automatic run_txn(input logic [3:0] amt, input logic ea, input logic eb, input logic ec,
                           input int ack_dly, input bit poke);
        @(negedge clk);
        empty_a = ea; empty_b = eb; empty_c = ec;
        coin_ack = (ack_dly == 0);
        start = 1'b1;
        amount = amt;
        @(negedge clk);
        start = 1'b0;
        amount = 4'($urandom_range(0, 15));
        monitor_txn(amt, ack_dly, poke, ea);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r_amt;
        logic       r_ea, r_eb, r_ec;
        int         r_dly;
        logic [15:0] seq;

        reset = 1'b0; start = 1'b0; amount = 4'd0; coin_ack = 1'b0;
        empty_a = 1'b0; empty_b = 1'b0; empty_c = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, error, coin_valid, coin_sel, remaining, coin_count, state_dbg}, 0);
        reset = 1'b1;

        vecs[0] = '{4'd13, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4, 16'h00E5, 4'd0, 1'b0};
        vecs[1] = '{4'd8,  1'b1, 1'b0, 1'b0, 0, 1'b0, 4, 16'h00AA, 4'd0, 1'b0};
        vecs[2] = '{4'd3,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1, 16'h0002, 4'd1, 1'b1};
        vecs[3] = '{4'd0,  1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 16'h0000, 4'd0, 1'b0};
        vecs[4] = '{4'd7,  1'b0, 1'b0, 1'b0, 3, 1'b1, 2, 16'h0009, 4'd0, 1'b0};
        vecs[5] = '{4'd15, 1'b0, 1'b0, 1'b0, 1, 1'b0, 3, 16'h0015, 4'd0, 1'b0};
        vecs[6] = '{4'd4,  1'b0, 1'b1, 1'b0, 2, 1'b0, 4, 16'h00FF, 4'd0, 1'b0};
        vecs[7] = '{4'd9,  1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 16'h0000, 4'd9, 1'b1};
        vecs[8] = '{4'd7,  1'b1, 1'b1, 1'b0, 0, 1'b0, 7, 16'h3FFF, 4'd0, 1'b0};

        for (int v = 0; v < 9; v++) begin
            exp_q.delete();
            seq = vecs[v].seq;
            for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(seq[2*k +: 2]);
            exp_rem = vecs[v].rem;
            exp_err = vecs[v].err;
            run_txn(vecs[v].amt, vecs[v].ea, vecs[v].eb, vecs[v].ec, vecs[v].dly, vecs[v].poke);
        end

        // Reset between edges while a coin is being presented.
        @(negedge clk);
        empty_a = 1'b0; empty_b = 1'b0; empty_c = 1'b0; coin_ack = 1'b0;
        start = 1'b1; amount = 4'd13;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !coin_valid; i++) @(negedge clk);
        check("issue_reached", coin_valid, 1);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", {busy, done, error, coin_valid, coin_sel, remaining, coin_count, state_dbg}, 0);
        @(negedge clk);
        reset = 1'b1; start = 1'b1; amount = 4'd5;
        model(5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        monitor_txn(5, 1, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            r_amt = 4'($urandom_range(0, 15));
            r_ea  = ($urandom_range(0, 3) == 0);
            r_eb  = ($urandom_range(0, 3) == 0);
            r_ec  = ($urandom_range(0, 3) == 0);
            r_dly = $urandom_range(0, 3);
            model(r_amt, r_ea, r_eb, r_ec);
            run_txn(r_amt, r_ea, r_eb, r_ec, r_dly, ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
